// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates instruction fetch and load/store onto one memory port
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wr_data,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rd_data,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wr_data,
   input  logic              m_ack,
   input  logic [DATA_W-1:0] m_rd_data
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_BUSY_I = 2'd1;
   localparam logic [1:0] S_BUSY_D = 2'd2;

   localparam logic [3:0] STREAK_LIMIT = 4'(STARVE_MAX);

   logic [1:0] state;
   logic [3:0] streak;
   logic       eff_i;
   logic       eff_d;
   logic       grant_i;
   logic       grant_d;

   // Pick a winner in IDLE; a requester whose response is on the bus this cycle is masked
   always_comb begin
      eff_i   = i_req & ~i_rvalid;
      eff_d   = d_req & ~d_rvalid;
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (state == S_IDLE) begin
         if (eff_d && eff_i) begin
            if (streak < STREAK_LIMIT) begin
               grant_d = 1'b1;
            end else begin
               grant_i = 1'b1;
            end
         end else begin
            grant_d = eff_d;
            grant_i = eff_i;
         end
      end
   end

   // Transaction FSM: launch the granted request, hold it until ack, then return the response
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         streak    <= 4'd0;
         m_req     <= 1'b0;
         m_we      <= 1'b0;
         m_addr    <= '0;
         m_wr_data <= '0;
         i_rvalid  <= 1'b0;
         d_rvalid  <= 1'b0;
         i_rdata   <= '0;
         d_rd_data <= '0;
      end else begin
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_d) begin
                  m_req     <= 1'b1;
                  m_we      <= d_we;
                  m_addr    <= d_addr;
                  m_wr_data <= d_wr_data;
                  state     <= S_BUSY_D;
                  // Only data wins taken over a waiting fetch count toward starvation
                  if (eff_i && (streak < STREAK_LIMIT)) begin
                     streak <= streak + 4'd1;
                  end
               end else if (grant_i) begin
                  m_req     <= 1'b1;
                  m_we      <= 1'b0;
                  m_addr    <= i_addr;
                  m_wr_data <= '0;
                  state     <= S_BUSY_I;
                  streak    <= 4'd0;
               end
            end
            S_BUSY_I: begin
               if (m_ack) begin
                  m_req    <= 1'b0;
                  state    <= S_IDLE;
                  i_rvalid <= 1'b1;
                  i_rdata  <= m_rd_data;
               end
            end
            S_BUSY_D: begin
               if (m_ack) begin
                  m_req     <= 1'b0;
                  state     <= S_IDLE;
                  d_rvalid  <= 1'b1;
                  d_rd_data <= m_we ? '0 : m_rd_data;
               end
            end
            default: begin
               state <= S_IDLE;
               m_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wr_data;
   logic        d_rvalid;
   logic [31:0] d_rd_data;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wr_data;
   logic        m_ack;
   logic [31:0] m_rd_data;

   typedef struct {
      string       name;
      bit          d_en;
      bit          d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      bit          i_en;
      logic [31:0] i_addr;
      logic [31:0] rd;
      int          delay;
   } vec_t;

   typedef struct {
      bit          is_d;
      logic [31:0] data;
   } rsp_t;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_t;

   rsp_t exp_rsp[$];
   mem_t exp_mem[$];

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          exp_streak = 0;
   int          ack_delay = 0;
   bit          ack_en = 1'b1;
   int          wait_cnt = 0;
   logic [31:0] rd_word = 32'd0;

   logic        prev_mreq = 1'b0;
   logic        prev_ack  = 1'b0;
   logic        prev_we   = 1'b0;
   logic [31:0] prev_addr = 32'd0;
   logic [31:0] prev_wd   = 32'd0;
   rsp_t        mon_r;
   mem_t        mon_m;

   vec_t vecs[6];

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wr_data(d_wr_data),
      .d_rvalid(d_rvalid), .d_rd_data(d_rd_data),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wr_data(m_wr_data),
      .m_ack(m_ack), .m_rd_data(m_rd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // memory model: ack after ack_delay wait cycles
   assign m_ack     = m_req && ack_en && (wait_cnt >= ack_delay);
   assign m_rd_data = rd_word;

   always @(posedge clk) begin
      if (rst || !(m_req && !m_ack)) wait_cnt <= 0;
      else                           wait_cnt <= wait_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic any_out();
      return |{m_req, m_we, m_addr, m_wr_data, i_rvalid, d_rvalid, i_rdata, d_rd_data};
   endfunction

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (i_rvalid || d_rvalid) begin
            chk("rvalid_exclusive", 32'(i_rvalid & d_rvalid), 32'd0);
            if (exp_rsp.size() == 0) begin
               chk("unexpected_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
            end else begin
               mon_r = exp_rsp.pop_front();
               chk("rsp_owner", 32'(d_rvalid), 32'(mon_r.is_d));
               chk("rsp_data", d_rvalid ? d_rd_data : i_rdata, mon_r.data);
            end
         end
         if (m_req && m_ack) begin
            if (exp_mem.size() == 0) begin
               chk("unexpected_mem_txn", m_addr, 32'hFFFF_FFFF);
            end else begin
               mon_m = exp_mem.pop_front();
               chk("mem_we", 32'(m_we), 32'(mon_m.we));
               chk("mem_addr", m_addr, mon_m.addr);
               chk("mem_wdata", m_wr_data, mon_m.wdata);
            end
         end
         if (m_req && prev_mreq && !prev_ack) begin
            chk("m_hold_addr", m_addr, prev_addr);
            chk("m_hold_wdata", m_wr_data, prev_wd);
            chk("m_hold_we", 32'(m_we), 32'(prev_we));
         end
         prev_mreq = m_req;
         prev_ack  = m_ack;
         prev_we   = m_we;
         prev_addr = m_addr;
         prev_wd   = m_wr_data;
      end else begin
         prev_mreq = 1'b0;
      end
   end

   task automatic push_d(input vec_t v);
      exp_mem.push_back('{v.d_we, v.d_addr, v.d_wdata});
      exp_rsp.push_back('{1'b1, v.d_we ? 32'd0 : v.rd});
   endtask

   task automatic push_i(input vec_t v);
      exp_mem.push_back('{1'b0, v.i_addr, 32'd0});
      exp_rsp.push_back('{1'b0, v.rd});
   endtask

   // drive one or both requesters, release each after its rvalid, check latency
   task automatic run_txn(input vec_t v);
      bit dd;
      bit id;
      bit d_first;
      int t0;
      int t_first;
      int t_second;
      int served;
      int n;
      int lat;
      lat      = 2 + v.delay;
      t_first  = 0;
      t_second = 0;
      served   = 0;
      n        = 0;
      rd_word   = v.rd;
      ack_delay = v.delay;
      d_first = v.d_en && !(v.i_en && exp_streak >= STARVE_MAX);
      if (d_first) begin
         push_d(v);
         if (v.i_en) push_i(v);
      end else begin
         push_i(v);
         if (v.d_en) push_d(v);
      end
      if (v.i_en) exp_streak = 0;
      @(posedge clk); #1;
      t0 = cyc;
      d_req = v.d_en; d_we = v.d_we; d_addr = v.d_addr; d_wr_data = v.d_wdata;
      i_req = v.i_en; i_addr = v.i_addr;
      dd = !v.d_en;
      id = !v.i_en;
      while (!(dd && id) && n < 40) begin
         @(negedge clk);
         if (d_rvalid && !dd) begin
            dd = 1'b1;
            if (served == 0) t_first = cyc; else t_second = cyc;
            served++;
         end
         if (i_rvalid && !id) begin
            id = 1'b1;
            if (served == 0) t_first = cyc; else t_second = cyc;
            served++;
         end
         @(posedge clk); #1;
         if (dd) d_req = 1'b0;
         if (id) i_req = 1'b0;
         n++;
      end
      chk({v.name, "_completed"}, 32'(dd && id), 32'd1);
      chk({v.name, "_latency"}, 32'(t_first - t0), 32'(lat));
      if (v.d_en && v.i_en) chk({v.name, "_second_latency"}, 32'(t_second - t_first), 32'(lat));
      @(negedge clk);
      chk({v.name, "_drained"}, 32'(exp_rsp.size() + exp_mem.size()), 32'd0);
   endtask

   task automatic wait_d_rvalid(input string name);
      int n;
      n = 0;
      while (!d_rvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_d_rvalid_seen"}, 32'(d_rvalid), 32'd1);
   endtask

   // data wins over a pending fetch, which then withdraws so the streak keeps growing
   task automatic starve_step(input int k);
      vec_t v;
      v = '{"starve", 1'b1, 1'b0, 32'h300 + 32'(4 * k), 32'd0, 1'b0, 32'd0, 32'h5000 + 32'(k), 0};
      ack_delay = 0;
      rd_word   = v.rd;
      push_d(v);
      if (exp_streak < STARVE_MAX) exp_streak++;
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b0; d_addr = v.d_addr; d_wr_data = 32'd0;
      i_req = 1'b1; i_addr = 32'h80;
      @(posedge clk); #1;
      i_req = 1'b0;
      @(negedge clk);
      wait_d_rvalid("starve");
      @(posedge clk); #1;
      d_req = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int cnt;
      vec_t v;
      vecs[0] = '{"single_load",   1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 32'h0,        32'hDEADBEEF, 0};
      vecs[1] = '{"fetch_wait",    1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h40,       32'hCAFEF00D, 3};
      vecs[2] = '{"contention",    1'b1, 1'b1, 32'h200, 32'h55,       1'b1, 32'h40,       32'h12345678, 0};
      vecs[3] = '{"store_wait",    1'b1, 1'b1, 32'h104, 32'hA5A5A5A5, 1'b0, 32'h0,        32'hFFFF0000, 1};
      vecs[4] = '{"both_wait",     1'b1, 1'b0, 32'h108, 32'h0,        1'b1, 32'h44,       32'h0BADF00D, 2};
      vecs[5] = '{"fetch_top",     1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF, 0};

      rst = 1'b1;
      i_req = 1'b0; i_addr = 32'd0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wr_data = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs_zero", 32'(any_out()), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 6; i++) run_txn(vecs[i]);

      // starvation: four data wins over a pending fetch, then fetch is forced
      for (int k = 0; k < STARVE_MAX; k++) starve_step(k);
      v = '{"forced_fetch", 1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 32'h84, 32'h600D600D, 0};
      run_txn(v);
      v = '{"after_forced", 1'b1, 1'b1, 32'h404, 32'h99, 1'b1, 32'h88, 32'h11112222, 0};
      run_txn(v);

      // reset while a load is stuck waiting for ack
      ack_en = 1'b0;
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; d_wr_data = 32'd0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("midop_m_req_before_reset", 32'(m_req), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midop_m_req_after_reset", 32'(m_req), 32'd0);
      chk("midop_no_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("midop_outputs_zero", 32'(any_out()), 32'd0);
      @(posedge clk); #1;
      d_req = 1'b0;
      ack_en = 1'b1;
      rst = 1'b0;
      exp_streak = 0;
      v = '{"fetch_after_reset", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h700, 32'h70707070, 1};
      run_txn(v);

      // requester drops d_req one cycle after grant
      v = '{"req_drop", 1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 32'h0, 32'h00000077, 2};
      rd_word = v.rd;
      ack_delay = v.delay;
      push_d(v);
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b0; d_addr = v.d_addr; d_wr_data = 32'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      d_req = 1'b0;
      @(negedge clk);
      wait_d_rvalid("req_drop");
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (m_req) cnt++;
      end
      chk("req_drop_no_second_mreq", 32'(cnt), 32'd0);
      chk("req_drop_drained", 32'(exp_rsp.size() + exp_mem.size()), 32'd0);
      chk("rdata_holds", d_rd_data, 32'h00000077);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck, expected completion");
      $fatal(1);
   end

endmodule
